// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction, waits for load data, drives the RF write port.
// Latency: 1 cycle capture-to-write for non-loads, >=2 for loads; ex_ready drops while a load waits.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_rd,
    input  logic [1:0]      ex_wb_sel,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_address,
    output logic [XLEN-1:0] rf_write_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [31:0]     instret,
    output logic            err_unexpected_rvalid
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RETIRE    = 2'd1;
    localparam logic [1:0] S_LOAD_WAIT = 2'd2;

    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    logic [1:0]      state;
    logic            reg_write_q;
    logic [4:0]      rd_q;
    logic [1:0]      wb_sel_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] load_q;
    logic [31:0]     instret_q;
    logic            err_q;

    logic            capture;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] result;

    assign ex_ready = (state != S_LOAD_WAIT);
    assign capture  = ex_ready && ex_valid;

    // Formatting uses the captured address, since rvalid arrives after capture.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (alu_q[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'd0:    ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd4:    ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'd1:    ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd5:    ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            WB_LOAD: result = load_q;
            WB_PC4:  result = pc_q + 32'd4;
            default: result = alu_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_RETIRE: begin
                    if (ex_valid)
                        state <= (ex_wb_sel == WB_LOAD) ? S_LOAD_WAIT : S_RETIRE;
                    else
                        state <= S_IDLE;
                end
                S_LOAD_WAIT: begin
                    if (dmem_rvalid)
                        state <= S_RETIRE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            pc_q        <= '0;
        end else if (capture) begin
            reg_write_q <= ex_reg_write;
            rd_q        <= ex_rd;
            wb_sel_q    <= ex_wb_sel;
            funct3_q    <= ex_funct3;
            alu_q       <= ex_alu_result;
            pc_q        <= ex_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_q <= '0;
        else if (state == S_LOAD_WAIT && dmem_rvalid)
            load_q <= ld_fmt;
    end

    // Every cycle spent in RETIRE retires exactly one instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (state == S_RETIRE)
            instret_q <= instret_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (dmem_rvalid && state != S_LOAD_WAIT)
            err_q <= 1'b1;
    end

    assign rf_write_enable       = (state == S_RETIRE) && reg_write_q && (rd_q != 5'd0);
    assign rf_write_address      = rd_q;
    assign rf_write_data         = result;
    assign fwd_valid             = rf_write_enable;
    assign fwd_rd                = rf_write_address;
    assign fwd_data              = rf_write_data;
    assign instret               = instret_q;
    assign err_unexpected_rvalid = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, load formatting, PC+4, reset mid-load, instret wrap.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] instret;
    logic        err_unexpected_rvalid;

    int n_checks;
    int n_errors;
    logic [31:0] exp_instret;

    wb_stage #(.XLEN(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ex_valid              (ex_valid),
        .ex_ready              (ex_ready),
        .ex_reg_write          (ex_reg_write),
        .ex_rd                 (ex_rd),
        .ex_wb_sel             (ex_wb_sel),
        .ex_funct3             (ex_funct3),
        .ex_alu_result         (ex_alu_result),
        .ex_pc                 (ex_pc),
        .dmem_rvalid           (dmem_rvalid),
        .dmem_rdata            (dmem_rdata),
        .rf_write_enable       (rf_write_enable),
        .rf_write_address      (rf_write_address),
        .rf_write_data         (rf_write_data),
        .fwd_valid             (fwd_valid),
        .fwd_rd                (fwd_rd),
        .fwd_data              (fwd_data),
        .instret               (instret),
        .err_unexpected_rvalid (err_unexpected_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic en, input logic [4:0] rd,
                               input logic [31:0] data);
        check({tag, "_we"}, {31'd0, rf_write_enable}, {31'd0, en});
        check({tag, "_fwd_vld"}, {31'd0, fwd_valid}, {31'd0, en});
        if (en) begin
            check({tag, "_addr"}, {27'd0, rf_write_address}, {27'd0, rd});
            check({tag, "_data"}, rf_write_data, data);
            check({tag, "_fwd_rd"}, {27'd0, fwd_rd}, {27'd0, rd});
            check({tag, "_fwd_data"}, fwd_data, data);
        end
    endtask

    task automatic drive_instr(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] pc);
        ex_valid      = 1'b1;
        ex_reg_write  = 1'b1;
        ex_rd         = rd;
        ex_wb_sel     = sel;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_pc         = pc;
    endtask

    // Load captured at edge N, rvalid sampled at edge N+waits, write checked right after.
    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int waits, input logic [31:0] exp);
        drive_instr(5'd7, 2'd1, f3, addr, 32'h0000_0100);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            check({tag, "_ready_low"}, {31'd0, ex_ready}, 32'd0);
            check({tag, "_no_we"}, {31'd0, rf_write_enable}, 32'd0);
            if (i == waits - 1) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
            end
            tick();
        end
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hDEAD_BEEF;
        check_write(tag, 1'b1, 5'd7, exp);
        check({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
        tick();
        exp_instret++;
        check({tag, "_instret"}, instret, exp_instret);
        check({tag, "_idle_we"}, {31'd0, rf_write_enable}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_instret   = 32'd0;
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_reg_write  = 1'b0;
        ex_rd         = 5'd0;
        ex_wb_sel     = 2'd0;
        ex_funct3     = 3'd0;
        ex_alu_result = 32'd0;
        ex_pc         = 32'd0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
        #12;
        check("rst_ready", {31'd0, ex_ready}, 32'd1);
        check("rst_we", {31'd0, rf_write_enable}, 32'd0);
        check("rst_addr", {27'd0, rf_write_address}, 32'd0);
        check("rst_data", rf_write_data, 32'd0);
        check("rst_fwd", {26'd0, fwd_valid, fwd_rd}, 32'd0);
        check("rst_fwd_data", fwd_data, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_err", {31'd0, err_unexpected_rvalid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU ops
        drive_instr(5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0000_0040);
        tick();
        check_write("alu0", 1'b1, 5'd5, 32'h0000_1234);
        drive_instr(5'd6, 2'd3, 3'd0, 32'h0000_ABCD, 32'h0000_0044);
        tick();
        exp_instret++;
        check_write("alu1", 1'b1, 5'd6, 32'h0000_ABCD);
        check("alu1_instret", instret, exp_instret);
        ex_valid = 1'b0;
        tick();
        exp_instret++;
        check("alu_instret", instret, 32'd2);
        check("alu_idle_we", {31'd0, rf_write_enable}, 32'd0);

        load_case("lb_off3",  3'd0, 32'h0000_0103, 32'h80FF_7F01, 3, 32'hFFFF_FF80);
        load_case("lbu_off3", 3'd4, 32'h0000_0103, 32'h80FF_7F01, 3, 32'h0000_0080);
        load_case("lb_off0",  3'd0, 32'h0000_0100, 32'h80FF_7F01, 1, 32'h0000_0001);
        load_case("lb_off2",  3'd0, 32'h0000_0102, 32'h80FF_7F01, 1, 32'hFFFF_FFFF);
        load_case("lbu_off1", 3'd4, 32'h0000_0101, 32'h80FF_7F01, 1, 32'h0000_007F);
        load_case("lh_hi",    3'd1, 32'h0000_0102, 32'h8001_1234, 1, 32'hFFFF_8001);
        load_case("lhu_hi",   3'd5, 32'h0000_0103, 32'h8001_1234, 2, 32'h0000_8001);
        load_case("lh_lo",    3'd1, 32'h0000_0101, 32'h8001_F234, 1, 32'hFFFF_F234);
        load_case("lhu_lo",   3'd5, 32'h0000_0100, 32'h8001_F234, 1, 32'h0000_F234);
        load_case("lw",       3'd2, 32'h0000_0100, 32'h8001_1234, 1, 32'h8001_1234);
        load_case("f3_7",     3'd7, 32'h0000_0103, 32'h8001_1234, 1, 32'h8001_1234);

        // PC+4 wraps; rd=0 suppresses the write but still retires
        drive_instr(5'd1, 2'd2, 3'd0, 32'h0000_0055, 32'hFFFF_FFFC);
        tick();
        check_write("jal_rd1", 1'b1, 5'd1, 32'h0000_0000);
        drive_instr(5'd0, 2'd2, 3'd0, 32'h0000_0055, 32'h0000_1000);
        tick();
        exp_instret++;
        check_write("jal_rd0", 1'b0, 5'd0, 32'h0);
        ex_valid = 1'b0;
        tick();
        exp_instret++;
        check("jal_instret", instret, exp_instret);

        // Reset while a load is pending, then a stray rvalid
        drive_instr(5'd9, 2'd1, 3'd2, 32'h0000_0200, 32'h0);
        tick();
        ex_valid = 1'b0;
        check("rstld_wait", {31'd0, ex_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        exp_instret = 32'd0;
        check("rstld_ready", {31'd0, ex_ready}, 32'd1);
        check("rstld_instret", instret, exp_instret);
        check("rstld_err0", {31'd0, err_unexpected_rvalid}, 32'd0);
        #2 rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        check("rstld_no_we", {31'd0, rf_write_enable}, 32'd0);
        check("rstld_err1", {31'd0, err_unexpected_rvalid}, 32'd1);
        tick();
        tick();
        check("rstld_err_sticky", {31'd0, err_unexpected_rvalid}, 32'd1);
        check("rstld_instret2", instret, 32'd0);

        // instret wrap from a forced near-max value
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        drive_instr(5'd3, 2'd0, 3'd0, 32'h0000_0077, 32'h0);
        tick();
        ex_valid = 1'b0;
        check_write("wrap_alu", 1'b1, 5'd3, 32'h0000_0077);
        tick();
        check("wrap_instret", instret, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
